// File: rtl/decim_framer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : decim_framer_pkg
// Description : Shared audio/FFT definitions used by the decimating framer:
//               default sample type, default decimation and FFT frame length,
//               and a helper that sizes wrapping counters.
// Revision    : 1.0 - initial release
// ============================================================================
package decim_framer_pkg;

  // Width of the filtered sample stream produced by the low-pass FIR stage.
  localparam int SAMPLE_W = 16;

  // Two's complement sample as carried between the FIR, framer and FFT.
  typedef logic signed [SAMPLE_W-1:0] sample_t;

  // Default decimation factor between the FIR output and the FFT input.
  localparam int DECIM_DEFAULT = 4;

  // Default FFT frame length in kept samples.
  localparam int FFT_FRAME_LEN = 1024;

  // Bits needed to hold a count in 0..max_count-1, never less than one bit so
  // that a modulus of 1 still yields a legal vector.
  function automatic int cnt_width(input int max_count);
    return (max_count <= 1) ? 1 : $clog2(max_count);
  endfunction

endpackage : decim_framer_pkg
`default_nettype wire

// File: rtl/decim_framer_counter.sv
`default_nettype none
// ============================================================================
// Module      : mod_counter
// Description : Wrapping modulo-MAX counter. Counts 0..MAX-1 on each enable
//               and wraps by explicit compare-to-max, so MAX need not be a
//               power of two. A clear forces the effective count to zero for
//               the current cycle, so an enable in the same cycle advances
//               from zero rather than from the stored value.
// Ports       :
//   clk      in   system clock
//   reset    in   synchronous active-high reset, count returns to 0
//   en_i     in   advance the counter this cycle
//   clr_i    in   treat the current count as 0 this cycle
//   zero_o   out  effective count is 0
//   wrap_o   out  effective count is MAX-1 (next advance wraps to 0)
// Revision    : 1.0 - initial release
// ============================================================================
module mod_counter
  import decim_framer_pkg::*;
#(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  input  logic clr_i,
  output logic zero_o,
  output logic wrap_o
);

  localparam int            CW    = cnt_width(MAX);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [CW-1:0] cnt_eff;

  // The clear acts on the value seen this cycle, not only on the next one.
  always_comb begin
    cnt_eff = clr_i ? '0 : cnt_q;
    cnt_d   = cnt_q;
    if (en_i) begin
      cnt_d = (cnt_eff == CNT_MAX) ? '0 : cnt_eff + CW'(1);
    end else if (clr_i) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_eff == '0);
  assign wrap_o = (cnt_eff == CNT_MAX);

endmodule : mod_counter
`default_nettype wire

// File: rtl/decim_framer.sv
`default_nettype none
// ============================================================================
// Module      : decim_framer
// Description : Decimates the filtered sample stream by DECIM (keeping the
//               first sample of each group) and groups kept samples into
//               frames of FRAME_LEN, flagging the last sample of each frame.
//               A single output register with ready/valid on both sides;
//               backpressure propagates straight upstream.
// Ports       :
//   clk          in   system clock
//   reset        in   synchronous active-high reset
//   x_data_i     in   filtered sample from upstream
//   x_valid_i    in   upstream sample valid
//   x_ready_o    out  block accepts x this cycle
//   y_data_o     out  decimated sample
//   y_valid_o    out  y_data_o holds an undelivered sample
//   y_ready_i    in   downstream accepts y this cycle
//   y_last_o     out  y_data_o is the last sample of a frame
//   restart_i    in   one-cycle pulse realigning phase and framing to zero
// Revision    : 1.0 - initial release
// ============================================================================
module decim_framer
  import decim_framer_pkg::*;
#(
  parameter int W         = SAMPLE_W,
  parameter int DECIM     = DECIM_DEFAULT,
  parameter int FRAME_LEN = FFT_FRAME_LEN
) (
  input  logic                clk,
  input  logic                reset,
  input  logic signed [W-1:0] x_data_i,
  input  logic                x_valid_i,
  output logic                x_ready_o,
  output logic signed [W-1:0] y_data_o,
  output logic                y_valid_o,
  input  logic                y_ready_i,
  output logic                y_last_o,
  input  logic                restart_i
);

  logic signed [W-1:0] y_data_q,  y_data_d;
  logic                y_valid_q, y_valid_d;
  logic                y_last_q,  y_last_d;

  logic accept;
  logic transfer;
  logic keep;
  logic phase_zero;
  logic phase_wrap;
  logic frame_zero;
  logic frame_wrap;

  // Ready depends only on the output register, so discarded samples are
  // accepted under exactly the same conditions as kept ones and nothing is
  // lost while the output is stalled.
  assign x_ready_o = !y_valid_q || y_ready_i;
  assign accept    = x_valid_i && x_ready_o;
  assign transfer  = y_valid_q && y_ready_i;
  assign keep      = accept && phase_zero;

  // Decimation phase: advances on every accepted sample.
  mod_counter #(
    .MAX    (DECIM)
  ) u_phase (
    .clk    (clk),
    .reset  (reset),
    .en_i   (accept),
    .clr_i  (restart_i),
    .zero_o (phase_zero),
    .wrap_o (phase_wrap)
  );

  // Frame index: advances only on kept samples; its wrap flag marks the
  // last sample of the frame.
  mod_counter #(
    .MAX    (FRAME_LEN)
  ) u_frame (
    .clk    (clk),
    .reset  (reset),
    .en_i   (keep),
    .clr_i  (restart_i),
    .zero_o (frame_zero),
    .wrap_o (frame_wrap)
  );

  // A kept sample always reloads the register, even in the cycle the old one
  // leaves, so back-to-back samples stream without a bubble. Restart does not
  // touch the held output.
  always_comb begin
    y_data_d  = y_data_q;
    y_valid_d = y_valid_q;
    y_last_d  = y_last_q;
    if (keep) begin
      y_data_d  = x_data_i;
      y_valid_d = 1'b1;
      y_last_d  = frame_wrap;
    end else if (transfer) begin
      y_valid_d = 1'b0;
      y_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      y_data_q  <= '0;
      y_valid_q <= 1'b0;
      y_last_q  <= 1'b0;
    end else begin
      y_data_q  <= y_data_d;
      y_valid_q <= y_valid_d;
      y_last_q  <= y_last_d;
    end
  end

  assign y_data_o  = y_data_q;
  assign y_valid_o = y_valid_q;
  assign y_last_o  = y_last_q;

  // Wrap and zero flags beyond those used above are kept for observability.
  logic unused_flags;
  assign unused_flags = phase_wrap ^ frame_zero;

endmodule : decim_framer
`default_nettype wire

// File: tb/tb_decim_framer.sv
`default_nettype none
// ============================================================================
// Module      : tb_decim_framer
// Description : Self-checking bench for decim_framer. Three instances cover
//               DECIM=4/FRAME_LEN=4, DECIM=1/FRAME_LEN=4 and
//               DECIM=3/FRAME_LEN=3. An arithmetic model counts accepted and
//               kept samples since the last reset/restart and is compared
//               with every instance on every cycle; directed streams are also
//               checked against hand-computed output lists.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decim_framer;

  localparam int NI = 3;
  localparam int DEC [NI] = '{4, 1, 3};
  localparam int FL  [NI] = '{4, 4, 3};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        restart = 1'b0;
  logic        y_ready = 1'b1;
  logic [15:0] x_data = '0;
  logic        x_valid [NI];
  logic        x_ready [NI];
  logic        y_valid [NI];
  logic        y_last  [NI];
  logic [15:0] y_data  [NI];

  always #5 clk = ~clk;

  decim_framer #(.W(16), .DECIM(4), .FRAME_LEN(4)) u_a (
    .clk(clk), .reset(reset), .x_data_i(x_data), .x_valid_i(x_valid[0]),
    .x_ready_o(x_ready[0]), .y_data_o(y_data[0]), .y_valid_o(y_valid[0]),
    .y_ready_i(y_ready), .y_last_o(y_last[0]), .restart_i(restart));

  decim_framer #(.W(16), .DECIM(1), .FRAME_LEN(4)) u_b (
    .clk(clk), .reset(reset), .x_data_i(x_data), .x_valid_i(x_valid[1]),
    .x_ready_o(x_ready[1]), .y_data_o(y_data[1]), .y_valid_o(y_valid[1]),
    .y_ready_i(y_ready), .y_last_o(y_last[1]), .restart_i(restart));

  decim_framer #(.W(16), .DECIM(3), .FRAME_LEN(3)) u_c (
    .clk(clk), .reset(reset), .x_data_i(x_data), .x_valid_i(x_valid[2]),
    .x_ready_o(x_ready[2]), .y_data_o(y_data[2]), .y_valid_o(y_valid[2]),
    .y_ready_i(y_ready), .y_last_o(y_last[2]), .restart_i(restart));

  int n_err = 0;
  int n_chk = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input int inst, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %0d, expected %0d (cycle %0d)", name, inst, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  // n = samples accepted since reset/restart, k = samples kept since then.
  int m_n [NI];
  int m_k [NI];
  bit m_valid [NI];
  bit m_last  [NI];
  int m_data  [NI];
  bit m_acc, m_xfer;

  initial begin
    for (int i = 0; i < NI; i++) begin
      m_n[i] = 0; m_k[i] = 0; m_valid[i] = 0; m_last[i] = 0; m_data[i] = 0;
      x_valid[i] = 1'b0;
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < NI; i++) begin
      if (reset) begin
        m_n[i] = 0; m_k[i] = 0; m_valid[i] = 0; m_last[i] = 0; m_data[i] = 0;
      end else begin
        m_acc  = x_valid[i] && (!m_valid[i] || y_ready);
        m_xfer = m_valid[i] && y_ready;
        if (restart) begin
          m_n[i] = 0;
          m_k[i] = 0;
        end
        if (m_acc && (m_n[i] % DEC[i] == 0)) begin
          m_data[i]  = int'(x_data);
          m_valid[i] = 1'b1;
          m_last[i]  = (m_k[i] % FL[i] == FL[i] - 1);
          m_k[i]     = m_k[i] + 1;
        end else if (m_xfer) begin
          m_valid[i] = 1'b0;
          m_last[i]  = 1'b0;
        end
        if (m_acc) m_n[i] = m_n[i] + 1;
      end
    end
  end

  // ---------------- per-cycle compare and transfer log ----------------
  typedef struct { int inst; int data; bit last; int cyc; } rec_t;
  rec_t got [$];

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < NI; i++) begin
        chk("x_ready", i, 32'(x_ready[i]), 32'(!m_valid[i] || y_ready));
        chk("y_valid", i, 32'(y_valid[i]), 32'(m_valid[i]));
        chk("y_data",  i, {16'h0, y_data[i]}, 32'(m_data[i]) & 32'hFFFF);
        if (m_valid[i]) chk("y_last", i, 32'(y_last[i]), 32'(m_last[i]));
        if (y_valid[i] === 1'b1 && y_ready)
          got.push_back('{i, int'(y_data[i]), y_last[i], cyc});
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  int e_d [$];
  int e_l [$];

  function automatic bit in_last(input int v);
    foreach (e_l[j]) if (e_l[j] == v) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check_seq(input string name, input int inst);
    int k;
    k = 0;
    foreach (got[j]) begin
      if (got[j].inst == inst) begin
        if (k < e_d.size()) begin
          chk({name, "_data"}, inst, 32'(got[j].data), 32'(e_d[k]));
          chk({name, "_last"}, inst, 32'(got[j].last), 32'(in_last(e_d[k])));
        end
        k++;
      end
    end
    chk({name, "_count"}, inst, 32'(k), 32'(e_d.size()));
  endtask

  task automatic do_reset();
    reset = 1'b1; restart = 1'b0; y_ready = 1'b1;
    for (int i = 0; i < NI; i++) x_valid[i] = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Offers values first..first+cnt-1 to one instance, advancing only on an
  // accept. restart pulses with the accept of rst_val; y_ready is low for
  // stream cycles in [stall_lo, stall_hi).
  task automatic stream(input int inst, input int first, input int cnt,
                        input int rst_val, input int stall_lo, input int stall_hi);
    int  v, sc;
    bit  acc, rdone;
    v = first; sc = 0; rdone = 1'b0;
    got.delete();
    while (v < first + cnt && sc < 500) begin
      x_valid[inst] = 1'b1;
      x_data        = 16'(v);
      restart       = (v == rst_val) && !rdone;
      y_ready       = !(sc >= stall_lo && sc < stall_hi);
      @(negedge clk);
      acc = x_ready[inst];
      @(posedge clk);
      #1;
      if (acc && restart) rdone = 1'b1;
      restart = 1'b0;
      if (acc) v++;
      sc++;
    end
    chk("stream_done", inst, 32'(v), 32'(first + cnt));
    x_valid[inst] = 1'b0;
    y_ready       = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  // ---------------- directed tests ----------------
  initial begin
    do_reset();
    chk_en = 1'b1;
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk("rst_y_valid", i, 32'(y_valid[i]), 32'd0);
      chk("rst_y_data",  i, {16'h0, y_data[i]}, 32'd0);
      chk("rst_y_last",  i, 32'(y_last[i]), 32'd0);
    end
    @(posedge clk); #1;

    // Continuous decimation, DECIM=4 FRAME_LEN=4.
    stream(0, 0, 32, -1, 0, 0);
    e_d = '{0, 4, 8, 12, 16, 20, 24, 28};
    e_l = '{12, 28};
    check_seq("cont", 0);

    // Backpressure: output held for 5 cycles while a sample is pending.
    do_reset();
    stream(0, 0, 16, -1, 5, 10);
    e_d = '{0, 4, 8, 12};
    e_l = '{12};
    check_seq("bp", 0);

    // Restart with the accept of 7 (phase 3): 7 becomes frame index 0.
    do_reset();
    stream(0, 0, 24, 7, 0, 0);
    e_d = '{0, 4, 7, 11, 15, 19, 23};
    e_l = '{19};
    check_seq("restart", 0);

    // Reset while stalled.
    do_reset();
    y_ready    = 1'b0;
    x_valid[0] = 1'b1;
    x_data     = 16'd9;
    @(posedge clk); #1;
    x_valid[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("stall_pre_valid", 0, 32'(y_valid[0]), 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_y_valid", 0, 32'(y_valid[0]), 32'd0);
    chk("midrst_y_data",  0, {16'h0, y_data[0]}, 32'd0);
    chk("midrst_y_last",  0, 32'(y_last[0]), 32'd0);
    @(posedge clk); #1;
    y_ready = 1'b1;
    stream(0, 50, 16, -1, 0, 0);
    e_d = '{50, 54, 58, 62};
    e_l = '{62};
    check_seq("postrst", 0);

    // DECIM=1: back-to-back loads with no bubble.
    do_reset();
    stream(1, 100, 3, -1, 0, 0);
    e_d = '{100, 101, 102};
    e_l.delete();
    check_seq("nobubble", 1);
    begin
      int c0, k;
      c0 = -1; k = 0;
      foreach (got[j]) begin
        if (got[j].inst == 1) begin
          if (c0 < 0) c0 = got[j].cyc;
          chk("nobubble_cycle", 1, 32'(got[j].cyc), 32'(c0 + k));
          k++;
        end
      end
    end

    // Non-power-of-two DECIM=3 FRAME_LEN=3.
    do_reset();
    stream(2, 0, 18, -1, 0, 0);
    e_d = '{0, 3, 6, 9, 12, 15};
    e_l = '{6, 15};
    check_seq("np2", 2);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1);
  end

endmodule : tb_decim_framer
`default_nettype wire
